// File: rtl/adder_tree_pkg.sv
// Shared definitions for the adder tree and its downstream stages: default
// widths derived from the tree adder width, the frame accumulator state
// encoding and the published frame result record.
package adder_tree_pkg;

  // Width of each tree adder operand; the registered tree sum carries one extra bit.
  localparam int ADDER_WIDTH   = 19;
  localparam int IN_WIDTH_DEF  = ADDER_WIDTH + 1;
  localparam int ACC_WIDTH_DEF = 32;
  localparam int MAX_COUNT_DEF = 256;

  // Bits needed for a beat counter that must reach max_count itself.
  function automatic int cnt_bits(input int max_count);
    return $clog2(max_count + 1);
  endfunction

  localparam int CNT_WIDTH_DEF = cnt_bits(MAX_COUNT_DEF);

  // IDLE: no partial frame held. ACCUM: acc/cnt hold a partial frame.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } accum_state_t;

  // Frame result as published at the default widths.
  typedef struct packed {
    logic [ACC_WIDTH_DEF-1:0] acc;
    logic [CNT_WIDTH_DEF-1:0] count;
    logic                     ovf;
  } accum_result_t;

endpackage

// File: rtl/adder_tree_accum_sat_add.sv
// Unsigned saturating adder: adds at one bit wider than the operands and
// clamps to all ones when the extra bit is set, reporting that as carry.
module sat_add #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  logic [WIDTH:0] full_sum;

  assign full_sum = {1'b0, a} + {1'b0, b};
  assign carry    = full_sum[WIDTH];
  assign sum      = carry ? '1 : full_sum[WIDTH-1:0];

endmodule

// File: rtl/adder_tree_accum.sv
// Frame accumulator behind the adder tree. Beats of the tree sum are added
// into a saturating accumulator until in_last or MAX_COUNT beats close the
// frame; the total, beat count and overflow flag are then held in a single
// valid/ready output register. A close and a consume in the same cycle
// replace the held result, so single-beat frames stream at full rate.
module adder_tree_accum
  import adder_tree_pkg::*;
#(
  parameter int IN_WIDTH  = IN_WIDTH_DEF,
  parameter int ACC_WIDTH = ACC_WIDTH_DEF,
  parameter int MAX_COUNT = MAX_COUNT_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_sum,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_acc,
  output logic [CNT_WIDTH-1:0] out_count,
  output logic                 out_ovf
);

  accum_state_t         state;
  logic [ACC_WIDTH-1:0] acc;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 ovf_int;

  logic                 accept;
  logic                 close;
  logic                 carry;
  logic [ACC_WIDTH-1:0] acc_prev;
  logic [ACC_WIDTH-1:0] acc_next;
  logic [ACC_WIDTH-1:0] sum_zext;
  logic [CNT_WIDTH-1:0] cnt_next;
  logic                 ovf_next;

  // Input is blocked only while a result is held and not being taken now.
  assign in_ready = !(out_valid && !out_ready);
  assign accept   = in_valid && in_ready;

  // A beat seen in IDLE starts a fresh frame, so nothing carries over from acc/cnt/ovf_int.
  assign acc_prev = (state == ACCUM) ? acc : '0;
  assign sum_zext = ACC_WIDTH'(in_sum);
  assign cnt_next = (state == ACCUM) ? cnt + CNT_WIDTH'(1) : CNT_WIDTH'(1);
  assign ovf_next = ((state == ACCUM) && ovf_int) || carry;

  // in_last and the beat limit landing together still give a single close.
  assign close = accept && (in_last || (cnt_next == CNT_WIDTH'(MAX_COUNT)));

  sat_add #(
    .WIDTH (ACC_WIDTH)
  ) u_sat_add (
    .a     (acc_prev),
    .b     (sum_zext),
    .sum   (acc_next),
    .carry (carry)
  );

  // Partial-frame state: advances only on accepted beats, clears on close.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      cnt     <= '0;
      ovf_int <= 1'b0;
    end else if (accept) begin
      if (close) begin
        state   <= IDLE;
        acc     <= '0;
        cnt     <= '0;
        ovf_int <= 1'b0;
      end else begin
        state   <= ACCUM;
        acc     <= acc_next;
        cnt     <= cnt_next;
        ovf_int <= ovf_next;
      end
    end
  end

  // Output register: loaded on close, released by a consume without a close.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else if (close) begin
      out_valid <= 1'b1;
      out_acc   <= acc_next;
      out_count <= cnt_next;
      out_ovf   <= ovf_next;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adder_tree_accum.sv
// Bench for adder_tree_accum. Three instances share one input stream:
// default widths, MAX_COUNT=4 and ACC_WIDTH=20. Each is tracked by a
// frame-level model (running integer total, clamp at the end) and checked
// every cycle, with directed scenarios adding fixed expected values.
module tb_adder_tree_accum;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [19:0] in_sum;
  logic        in_last;
  logic        out_ready;

  logic        d0_in_ready, d0_out_valid, d0_out_ovf;
  logic [31:0] d0_out_acc;
  logic [8:0]  d0_out_count;
  logic        d1_in_ready, d1_out_valid, d1_out_ovf;
  logic [31:0] d1_out_acc;
  logic [2:0]  d1_out_count;
  logic        d2_in_ready, d2_out_valid, d2_out_ovf;
  logic [19:0] d2_out_acc;
  logic [8:0]  d2_out_count;

  always #5 clk = ~clk;

  adder_tree_accum u_dut_def (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(d0_in_ready),
    .in_sum(in_sum), .in_last(in_last), .out_valid(d0_out_valid), .out_ready(out_ready),
    .out_acc(d0_out_acc), .out_count(d0_out_count), .out_ovf(d0_out_ovf)
  );

  adder_tree_accum #(.MAX_COUNT(4), .CNT_WIDTH(3)) u_dut_mc4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(d1_in_ready),
    .in_sum(in_sum), .in_last(in_last), .out_valid(d1_out_valid), .out_ready(out_ready),
    .out_acc(d1_out_acc), .out_count(d1_out_count), .out_ovf(d1_out_ovf)
  );

  adder_tree_accum #(.ACC_WIDTH(20)) u_dut_a20 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(d2_in_ready),
    .in_sum(in_sum), .in_last(in_last), .out_valid(d2_out_valid), .out_ready(out_ready),
    .out_acc(d2_out_acc), .out_count(d2_out_count), .out_ovf(d2_out_ovf)
  );

  // Uniform views of the three instances, indexed 0=def, 1=mc4, 2=a20.
  logic [2:0]       rdy, vld, ovf;
  logic [2:0][31:0] oacc;
  logic [2:0][8:0]  ocnt;
  logic [2:0]       rdy_seen;

  assign rdy  = {d2_in_ready, d1_in_ready, d0_in_ready};
  assign vld  = {d2_out_valid, d1_out_valid, d0_out_valid};
  assign ovf  = {d2_out_ovf, d1_out_ovf, d0_out_ovf};
  assign oacc = {{12'd0, d2_out_acc}, d1_out_acc, d0_out_acc};
  assign ocnt = {d2_out_count, {6'd0, d1_out_count}, d0_out_count};

  // Frame-level model state per instance.
  longint amax [3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'h000F_FFFF};
  int     maxc [3] = '{256, 4, 256};
  string  dname[3] = '{"def", "mc4", "a20"};
  longint m_sum [3];
  int     m_cnt [3];
  bit     m_ov  [3];
  longint m_oacc[3];
  int     m_ocnt[3];
  bit     m_oovf[3];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      m_sum[i] = 0; m_cnt[i] = 0; m_ov[i] = 0;
      m_oacc[i] = 0; m_ocnt[i] = 0; m_oovf[i] = 0;
    end
  endtask

  // One clock cycle: drive at negedge, check in_ready, advance models on the
  // edge, then check all result outputs.
  task automatic step(input bit v, input logic [19:0] s, input bit l, input bit r);
    bit     exp_rdy, close, prev_ov;
    longint tot;
    int     c;
    @(negedge clk);
    in_valid = v; in_sum = s; in_last = l; out_ready = r;
    #1;
    rdy_seen = rdy;
    for (int i = 0; i < 3; i++) begin
      exp_rdy = !(m_ov[i] && !r);
      n_cmp++;
      if (rdy[i] !== exp_rdy) begin
        n_bad++;
        $display("FAIL in_ready[%s] t=%0t: got %b want %b", dname[i], $time, rdy[i], exp_rdy);
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      exp_rdy = !(m_ov[i] && !r);
      prev_ov = m_ov[i];
      close   = 0;
      if (v && exp_rdy) begin
        tot = m_sum[i] + longint'(s);
        c   = m_cnt[i] + 1;
        close = l || (c == maxc[i]);
        if (close) begin
          m_oacc[i] = (tot > amax[i]) ? amax[i] : tot;
          m_ocnt[i] = c;
          m_oovf[i] = (tot > amax[i]);
          m_sum[i]  = 0;
          m_cnt[i]  = 0;
        end else begin
          m_sum[i] = tot;
          m_cnt[i] = c;
        end
      end
      if (close) m_ov[i] = 1;
      else if (prev_ov && r) m_ov[i] = 0;

      n_cmp++;
      if (vld[i] !== m_ov[i] || oacc[i] !== m_oacc[i][31:0] ||
          ocnt[i] !== 9'(m_ocnt[i]) || ovf[i] !== m_oovf[i]) begin
        n_bad++;
        $display("FAIL outputs[%s] t=%0t: got v=%b acc=%0d cnt=%0d ovf=%b want v=%b acc=%0d cnt=%0d ovf=%b",
                 dname[i], $time, vld[i], oacc[i], ocnt[i], ovf[i],
                 m_ov[i], m_oacc[i], m_ocnt[i], m_oovf[i]);
      end
    end
  endtask

  // One reset edge with live-looking inputs, then release with the bus idle.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b1; in_last = 1'b1; in_sum = 20'($urandom); out_ready = 1'b0;
    @(posedge clk);
    #1;
    model_clear();
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (vld[i] !== 1'b0 || oacc[i] !== 32'd0 || ocnt[i] !== 9'd0 || ovf[i] !== 1'b0) begin
        n_bad++;
        $display("FAIL reset[%s]: got v=%b acc=%0d cnt=%0d ovf=%b want all zero",
                 dname[i], vld[i], oacc[i], ocnt[i], ovf[i]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_basic_frame();
    do_reset();
    step(1, 20'd100, 0, 1);
    step(1, 20'd200, 0, 1);
    n_cmp++;
    if (vld[0] !== 1'b0) begin
      n_bad++; $display("FAIL basic_early_valid: got %b want 0", vld[0]);
    end
    step(1, 20'd300, 1, 1);
    n_cmp++;
    if (vld[0] !== 1'b1 || oacc[0] !== 32'd600 || ocnt[0] !== 9'd3 || ovf[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_frame: got v=%b acc=%0d cnt=%0d ovf=%b want v=1 acc=600 cnt=3 ovf=0",
               vld[0], oacc[0], ocnt[0], ovf[0]);
    end
    step(0, 20'd0, 0, 1);
    n_cmp++;
    if (vld[0] !== 1'b0) begin
      n_bad++; $display("FAIL basic_consume: got v=%b want 0", vld[0]);
    end
  endtask

  task automatic test_single_beat();
    step(1, 20'hFFFFF, 1, 1);
    n_cmp++;
    if (vld[0] !== 1'b1 || oacc[0] !== 32'd1048575 || ocnt[0] !== 9'd1) begin
      n_bad++;
      $display("FAIL single_beat: got v=%b acc=%0d cnt=%0d want v=1 acc=1048575 cnt=1",
               vld[0], oacc[0], ocnt[0]);
    end
    n_cmp++;
    if (oacc[2] !== 32'hFFFFF || ovf[2] !== 1'b0) begin
      n_bad++;
      $display("FAIL single_beat_a20_exact_max: got acc=%0h ovf=%b want acc=fffff ovf=0", oacc[2], ovf[2]);
    end
    step(0, 20'd0, 0, 1);
  endtask

  task automatic test_max_count();
    do_reset();
    for (int k = 0; k < 4; k++) step(1, 20'd1, 0, 1);
    n_cmp++;
    if (vld[1] !== 1'b1 || oacc[1] !== 32'd4 || ocnt[1] !== 9'd4) begin
      n_bad++;
      $display("FAIL max_count_close: got v=%b acc=%0d cnt=%0d want v=1 acc=4 cnt=4", vld[1], oacc[1], ocnt[1]);
    end
    step(1, 20'd1, 0, 1);
    n_cmp++;
    if (vld[1] !== 1'b0) begin
      n_bad++; $display("FAIL max_count_fifth_no_close: got v=%b want 0", vld[1]);
    end
    step(1, 20'd0, 1, 1);
    n_cmp++;
    if (oacc[1] !== 32'd1 || ocnt[1] !== 9'd2 || oacc[0] !== 32'd5 || ocnt[0] !== 9'd6) begin
      n_bad++;
      $display("FAIL max_count_new_frame: got mc4 acc=%0d cnt=%0d def acc=%0d cnt=%0d want 1/2 and 5/6",
               oacc[1], ocnt[1], oacc[0], ocnt[0]);
    end
    // in_last on the MAX_COUNT-th beat closes exactly once.
    for (int k = 0; k < 3; k++) step(1, 20'd2, 0, 1);
    step(1, 20'd2, 1, 1);
    n_cmp++;
    if (vld[1] !== 1'b1 || oacc[1] !== 32'd8 || ocnt[1] !== 9'd4) begin
      n_bad++;
      $display("FAIL last_at_max: got v=%b acc=%0d cnt=%0d want v=1 acc=8 cnt=4", vld[1], oacc[1], ocnt[1]);
    end
    step(1, 20'd5, 1, 1);
    n_cmp++;
    if (oacc[1] !== 32'd5 || ocnt[1] !== 9'd1) begin
      n_bad++;
      $display("FAIL after_last_at_max: got acc=%0d cnt=%0d want acc=5 cnt=1", oacc[1], ocnt[1]);
    end
    step(0, 20'd0, 0, 1);
  endtask

  task automatic test_saturation();
    do_reset();
    step(1, 20'hFFFFF, 0, 1);
    step(1, 20'd1, 1, 1);
    n_cmp++;
    if (vld[2] !== 1'b1 || oacc[2] !== 32'hFFFFF || ocnt[2] !== 9'd2 || ovf[2] !== 1'b1) begin
      n_bad++;
      $display("FAIL saturate_a20: got v=%b acc=%0h cnt=%0d ovf=%b want v=1 acc=fffff cnt=2 ovf=1",
               vld[2], oacc[2], ocnt[2], ovf[2]);
    end
    n_cmp++;
    if (oacc[0] !== 32'h100000 || ovf[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL wide_no_saturate: got acc=%0h ovf=%b want acc=100000 ovf=0", oacc[0], ovf[0]);
    end
    step(1, 20'd5, 1, 1);
    n_cmp++;
    if (oacc[2] !== 32'd5 || ovf[2] !== 1'b0) begin
      n_bad++;
      $display("FAIL saturate_next_frame: got acc=%0d ovf=%b want acc=5 ovf=0", oacc[2], ovf[2]);
    end
    // Saturation sticks for the rest of the frame even when later beats add nothing.
    step(1, 20'hFFFFF, 0, 1);
    step(1, 20'hFFFFF, 0, 1);
    step(1, 20'd0, 1, 1);
    n_cmp++;
    if (oacc[2] !== 32'hFFFFF || ovf[2] !== 1'b1 || ocnt[2] !== 9'd3) begin
      n_bad++;
      $display("FAIL saturate_sticky: got acc=%0h ovf=%b cnt=%0d want acc=fffff ovf=1 cnt=3",
               oacc[2], ovf[2], ocnt[2]);
    end
    step(0, 20'd0, 0, 1);
  endtask

  task automatic test_backpressure();
    do_reset();
    step(1, 20'd7, 0, 1);
    step(1, 20'd3, 1, 0);
    n_cmp++;
    if (vld[0] !== 1'b1 || oacc[0] !== 32'd10 || ocnt[0] !== 9'd2) begin
      n_bad++;
      $display("FAIL bp_close: got v=%b acc=%0d cnt=%0d want v=1 acc=10 cnt=2", vld[0], oacc[0], ocnt[0]);
    end
    // Held result: input blocked, in_last ignored, outputs frozen.
    for (int k = 0; k < 3; k++) begin
      step(1, 20'(k + 40), 1, 0);
      n_cmp++;
      if (rdy_seen[0] !== 1'b0 || vld[0] !== 1'b1 || oacc[0] !== 32'd10 || ocnt[0] !== 9'd2) begin
        n_bad++;
        $display("FAIL bp_hold: got rdy=%b v=%b acc=%0d cnt=%0d want rdy=0 v=1 acc=10 cnt=2",
                 rdy_seen[0], vld[0], oacc[0], ocnt[0]);
      end
    end
    // Consume while starting a partial frame, then stall the input.
    step(1, 20'd4, 0, 1);
    step(0, 20'd99, 1, 0);
    step(0, 20'd99, 1, 0);
    step(1, 20'd6, 1, 1);
    n_cmp++;
    if (vld[0] !== 1'b1 || oacc[0] !== 32'd10 || ocnt[0] !== 9'd2) begin
      n_bad++;
      $display("FAIL bp_partial_survives: got v=%b acc=%0d cnt=%0d want v=1 acc=10 cnt=2",
               vld[0], oacc[0], ocnt[0]);
    end
    step(0, 20'd0, 0, 1);
  endtask

  task automatic test_back_to_back();
    do_reset();
    step(1, 20'd11, 1, 0);
    step(1, 20'd22, 1, 1);
    n_cmp++;
    if (vld[0] !== 1'b1 || oacc[0] !== 32'd22) begin
      n_bad++; $display("FAIL b2b_replace: got v=%b acc=%0d want v=1 acc=22", vld[0], oacc[0]);
    end
    step(1, 20'd33, 1, 1);
    n_cmp++;
    if (vld[0] !== 1'b1 || oacc[0] !== 32'd33 || ocnt[0] !== 9'd1) begin
      n_bad++; $display("FAIL b2b_second: got v=%b acc=%0d cnt=%0d want v=1 acc=33 cnt=1", vld[0], oacc[0], ocnt[0]);
    end
    step(0, 20'd0, 0, 1);
    n_cmp++;
    if (vld[0] !== 1'b0) begin
      n_bad++; $display("FAIL b2b_drain: got v=%b want 0", vld[0]);
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    step(1, 20'd2, 1, 1);
    step(1, 20'd50, 0, 1);
    do_reset();
    step(1, 20'd9, 1, 1);
    n_cmp++;
    if (oacc[0] !== 32'd9 || ocnt[0] !== 9'd1) begin
      n_bad++; $display("FAIL reset_partial_discard: got acc=%0d cnt=%0d want acc=9 cnt=1", oacc[0], ocnt[0]);
    end
    step(1, 20'd8, 1, 0);
    do_reset();
    step(1, 20'd9, 1, 1);
    n_cmp++;
    if (vld[0] !== 1'b1 || oacc[0] !== 32'd9) begin
      n_bad++; $display("FAIL reset_pending_discard: got v=%b acc=%0d want v=1 acc=9", vld[0], oacc[0]);
    end
    step(0, 20'd0, 0, 1);
  endtask

  task automatic test_random();
    logic [19:0] s;
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      s = ($urandom_range(0, 7) == 0) ? 20'hFFFFF : 20'($urandom);
      step($urandom_range(0, 3) != 0, s, $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0);
    end
    // Long frames so the default instance reaches its 256-beat limit.
    for (int k = 0; k < 700; k++) begin
      step($urandom_range(0, 3) != 0, 20'($urandom), 1'b0, $urandom_range(0, 3) != 0);
    end
  endtask

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; in_sum = '0; in_last = 1'b0; out_ready = 1'b0;
    rdy_seen = '0;
    model_clear();
    test_reset();
    test_basic_frame();
    test_single_beat();
    test_max_count();
    test_saturation();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
